// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared FSM state type and 50 MHz default timing constants
// for the pushbutton conditioner.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    // 20 ms of stable contact at 50 MHz
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    // 0.5 s hold before the first auto-repeat
    localparam int unsigned DEF_REPEAT_DELAY    = 25_000_000;
    // 0.2 s between subsequent auto-repeats
    localparam int unsigned DEF_REPEAT_PERIOD   = 10_000_000;

    // Larger of two unsigned values, used for counter sizing.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_if.sv
// key_debounce_if: raw key input and conditioned outputs of one pushbutton.
//   key_n : raw active-low pushbutton (driven by master)
//   level : debounced pressed state   (driven by slave)
//   pulse : one-cycle press strobe    (driven by slave)
interface key_debounce_if;
    logic key_n;
    logic level;
    logic pulse;

    modport master (
        output key_n,
        input  level,
        input  pulse
    );

    modport slave (
        input  key_n,
        output level,
        output pulse
    );
endinterface

// File: rtl/key_debounce_sync_2ff.sv
// sync_2ff: generic two-flop synchroniser for asynchronous board inputs.
//   clk : destination clock
//   rst : asynchronous active-low reset, both flops load RST_VAL
//   d   : asynchronous input
//   q   : synchronised output (two cycles of latency)
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; second gives it a full cycle to settle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// key_debounce: conditions a raw active-low DE1 KEY into a debounced level and
// a single-cycle pulse per accepted press, suitable as a counter enable.
//   clk      : system clock (CLOCK_50)
//   rst      : asynchronous active-low reset
//   kif      : key_debounce_if.slave (key_n in, level/pulse out, both registered)
// Optional feature: define KEY_AUTOREPEAT_EN to emit repeat pulses while the
// key stays held (REPEAT_DELAY before the first, REPEAT_PERIOD afterwards).
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic       clk,
    input  logic       rst,
    key_debounce_if.slave kif
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Elaboration-time parameter sanity checks
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 32'd16_777_216) begin : g_bad_debounce
        $error("key_debounce: DEBOUNCE_CYCLES must be in 2..2^24");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("key_debounce: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
    end

    logic            key_sync_n;
    logic            k;
    key_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            pulse_q, pulse_d;

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned RW = $clog2(max_u(max_u(REPEAT_DELAY, REPEAT_PERIOD), 2));
    localparam logic [RW-1:0] RDLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPER_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0]   rcnt_q, rcnt_d;
    // Set once the first repeat has fired; selects period instead of delay.
    logic            rep_q, rep_d;
`endif

    // Released (1) is the safe reset value so reset never looks like a press.
    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (kif.key_n),
        .q   (key_sync_n)
    );

    assign k = ~key_sync_n;

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rcnt_q  <= '0;
            rep_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
`ifdef KEY_AUTOREPEAT_EN
            rcnt_q  <= rcnt_d;
            rep_q   <= rep_d;
`endif
        end
    end

    // Next-state, counter and registered-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rcnt_d  = rcnt_q;
        rep_d   = rep_q;
`endif

        case (state_q)
            IDLE: begin
                if (k) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end

            PRESS_WAIT: begin
                if (!k) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                    rcnt_d  = '0;
                    rep_d   = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            PRESSED: begin
                if (!k) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
`ifdef KEY_AUTOREPEAT_EN
                // rcnt is left untouched by RELEASE_WAIT so a bounce resumes it.
                else if (rcnt_q == (rep_q ? RPER_LAST : RDLY_LAST)) begin
                    pulse_d = 1'b1;
                    rcnt_d  = '0;
                    rep_d   = 1'b1;
                end else begin
                    rcnt_d = rcnt_q + RW'(1);
                end
`endif
            end

            RELEASE_WAIT: begin
                if (k) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // level registers the pressed-side states of the upcoming cycle
        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    assign kif.level = level_q;
    assign kif.pulse = pulse_q;

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed bench for key_debounce with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3. Expected pulse cycles are queued when a
// press is driven and matched as pulses appear.
module tb_key_debounce;

    localparam int unsigned DEB = 4;
    localparam int unsigned RD  = 10;
    localparam int unsigned RP  = 3;
    localparam int          LAT = DEB + 3;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    int   sb[$];
    logic cnt_clr;
    logic [3:0] cnt_val;

    key_debounce_if kif();

    key_debounce #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream hex-digit counter enabled by pulse
    initial cnt_val = '0;
    always @(posedge clk) begin
        if (cnt_clr)        cnt_val <= '0;
        else if (kif.pulse) cnt_val <= cnt_val + 4'd1;
    end

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Scoreboard: every pulse must match the head of the queue, and a queued
    // cycle reached without a pulse is a missed pulse.
    always @(negedge clk) begin
        int exp_c;
        if (kif.pulse || (sb.size() > 0 && cyc >= sb[0])) begin
            exp_c = (sb.size() > 0) ? sb.pop_front() : -1;
            checks++;
            assert (kif.pulse === 1'b1 && cyc === exp_c) else begin
                errors++;
                $error("FAIL pulse: observed pulse=%b at cycle %0d, expected pulse at cycle %0d",
                       kif.pulse, cyc, exp_c);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        kif.key_n = 1'b1;
        cnt_clr   = 1'b0;
        cycles(3);

        // Reset state
        chk("reset_level", 32'(kif.level), 32'd0);
        chk("reset_pulse", 32'(kif.pulse), 32'd0);
        rst = 1'b1;
        cycles(3);
        chk("idle_level", 32'(kif.level), 32'd0);

        // Clean press: pulse and level rise seven edges after the first sample
        kif.key_n = 1'b0;
        sb.push_back(cyc + LAT);
        cycles(LAT - 1);
        chk("press_level_early", 32'(kif.level), 32'd0);
        cycles(1);
        chk("press_level", 32'(kif.level), 32'd1);
        chk("press_pulse", 32'(kif.pulse), 32'd1);
        cycles(1);
        chk("press_pulse_one_cycle", 32'(kif.pulse), 32'd0);
        cycles(2);
        chk("press_level_hold", 32'(kif.level), 32'd1);

        // Clean release
        kif.key_n = 1'b1;
        cycles(LAT - 1);
        chk("release_level_early", 32'(kif.level), 32'd1);
        cycles(1);
        chk("release_level", 32'(kif.level), 32'd0);
        cycles(3);

        // Press bounce: 2-cycle glitches are rejected, then a real press
        for (int i = 0; i < 5; i++) begin
            kif.key_n = 1'b0;
            cycles(2);
            kif.key_n = 1'b1;
            cycles(2);
        end
        chk("bounce_level", 32'(kif.level), 32'd0);
        kif.key_n = 1'b0;
        sb.push_back(cyc + LAT);
        cycles(LAT);
        chk("bounce_press_level", 32'(kif.level), 32'd1);
        cycles(2);
        kif.key_n = 1'b1;
        cycles(LAT + 1);
        chk("bounce_release_level", 32'(kif.level), 32'd0);
        cycles(2);

        // Release bounce: 3-cycle release keeps level high, no second pulse
        kif.key_n = 1'b0;
        sb.push_back(cyc + LAT);
        cycles(LAT + 1);
        kif.key_n = 1'b1;
        cycles(3);
        kif.key_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycles(1);
            chk("relbounce_level", 32'(kif.level), 32'd1);
        end
        kif.key_n = 1'b1;
        cycles(LAT + 1);
        chk("relbounce_release_level", 32'(kif.level), 32'd0);
        cycles(2);

        // Reset during PRESS_WAIT aborts; key still held afterwards re-presses
        kif.key_n = 1'b0;
        cycles(4);
        rst = 1'b0;
        #1;
        chk("midrst_level", 32'(kif.level), 32'd0);
        chk("midrst_pulse", 32'(kif.pulse), 32'd0);
        cycles(3);
        chk("midrst_hold_pulse", 32'(kif.pulse), 32'd0);
        rst = 1'b1;
        sb.push_back(cyc + LAT);
        cycles(LAT);
        chk("postrst_level", 32'(kif.level), 32'd1);
        kif.key_n = 1'b1;
        cycles(LAT + 1);
        chk("postrst_release_level", 32'(kif.level), 32'd0);
        cycles(2);

        // Counter chain: five bounced presses advance the digit to 5
        cnt_clr = 1'b1;
        cycles(1);
        cnt_clr = 1'b0;
        for (int p = 0; p < 5; p++) begin
            for (int b = 0; b < 3; b++) begin
                kif.key_n = 1'b0;
                cycles(2);
                kif.key_n = 1'b1;
                cycles(2);
            end
            kif.key_n = 1'b0;
            sb.push_back(cyc + LAT);
            cycles(LAT + 2);
            kif.key_n = 1'b1;
            cycles(2);
            kif.key_n = 1'b0;
            cycles(2);
            kif.key_n = 1'b1;
            cycles(LAT + 2);
        end
        chk("counter_value", 32'(cnt_val), 32'd5);
        chk("counter_hex0", 32'(hex7(cnt_val)), 32'b0010010);

        // Long hold: auto-repeat pulses only when the feature is built in
        begin
            int first;
            kif.key_n = 1'b0;
            first = cyc + LAT;
            sb.push_back(first);
`ifdef KEY_AUTOREPEAT_EN
            // Release is driven at first+30; FSM sees it from first+33 on
            for (int t = first + int'(RD); t <= first + 32; t += int'(RP))
                sb.push_back(t);
`endif
            cycles(LAT);
            chk("hold_level", 32'(kif.level), 32'd1);
            cycles(30);
            kif.key_n = 1'b1;
            cycles(LAT + 1);
            chk("hold_release_level", 32'(kif.level), 32'd0);
        end
        cycles(5);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
